// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver. The line input is synchronized and then deframed by an FSM
// that samples each bit at its midpoint. Completed bytes go to a holding stage
// that the consumer drains over a ready/valid handshake.
//
// Ports:
//   clk            core clock
//   rst            synchronous active-high reset
//   serial_in      asynchronous serial line, idles high
//   data_out       received byte (head of the holding stage)
//   data_out_valid holding stage has a byte
//   data_out_ready consumer takes the byte on valid && ready
//   framing_err    one-cycle pulse when the stop bit is sampled 0
//   overrun        one-cycle pulse when a completed byte is dropped
//
// Build option: define UART_RX_FIFO_EN for a 4-entry holding FIFO; the default
// build uses a single holding register.
module uart_rx_core #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_err,
  output logic       overrun
);
  localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME = SYMBOL_TIME / 2;
  localparam int CW          = $clog2(SYMBOL_TIME);
  localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_TIME - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic          sync1_q, rx_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          push;

  // Both synchronizer flops reset to the idle level so reset never fakes a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == SMP_LAST) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == SYM_LAST) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Sampled mid-stop-bit; returning to IDLE here lets the next start
        // edge be caught during the second half of the stop bit.
        if (cnt_q == SYM_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low must go high before another frame can start.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  // 4-entry FIFO; pointer bit 2 is the wrap bit distinguishing full from empty.
  logic [3:0][7:0] mem_q, mem_d;
  logic [2:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic            empty, full, pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[1:0] == rptr_q[1:0]) && (wptr_q[2] != rptr_q[2]);
  assign pop   = !empty && data_out_ready;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovr_d  = 1'b0;
    if (pop) rptr_d = rptr_q + 3'd1;
    if (push) begin
      // A pop in the same cycle frees a slot, so full+pop+push is accepted.
      if (!full || pop) begin
        mem_d[wptr_q[1:0]] = shreg_q;
        wptr_d             = wptr_q + 3'd1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign data_out       = mem_q[rptr_q[1:0]];
  assign data_out_valid = !empty;
`else
  logic [7:0] hold_q, hold_d;
  logic       vld_q, vld_d, pop;

  assign pop = vld_q && data_out_ready;

  always_comb begin
    hold_d = hold_q;
    vld_d  = vld_q;
    ovr_d  = 1'b0;
    if (pop) vld_d = 1'b0;
    if (push) begin
      // The old byte wins when it is still unaccepted; otherwise load the new one.
      if (!vld_q || pop) begin
        hold_d = shreg_q;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out       = hold_q;
  assign data_out_valid = vld_q;
`endif

  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel UART receiver for the SMU RV32I system's `UART_RXD` pin. It deframes 8N1 characters at a fixed baud rate and presents each byte on a ready/valid interface to the memory-mapped UART register block. It is the receive half facing the host's transmitter, and it must sustain the echo workload: back-to-back characters at 1 Mbaud with a 50 MHz core clock.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000: core clock frequency in Hz.
- `BAUD_RATE`, 1_000_000: line rate in baud.
- Derived, local: `SYMBOL_TIME` = CLOCK_FREQ/BAUD_RATE, integer division, 50 by default. `SAMPLE_TIME` = SYMBOL_TIME/2, 25 by default. Counter width = $clog2(SYMBOL_TIME).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `serial_in`  in  1  asynchronous line input; idles high.
- `data_out`  out  8  received byte.
- `data_out_valid`  out  1  byte available.
- `data_out_ready`  in  1  consumer accepts the byte on `valid && ready`.
- `framing_err`  out  1  one-cycle pulse when the stop bit is sampled 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer.** `serial_in` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized bit `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** wait for `rx_s`==0. On that cycle, clear `cnt` and go to START.
- **START:** on `cnt`==SAMPLE_TIME-1, sample `rx_s`.
  - Sample 1: false start; return to IDLE and record nothing.
  - Sample 0: clear `cnt`, clear `bit_idx`, go to DATA.
- **DATA:** on `cnt`==SYMBOL_TIME-1, shift `rx_s` into the shift register LSB-first, clear `cnt`, increment `bit_idx`. After the 8th bit, go to STOP.
- **STOP:** on `cnt`==SYMBOL_TIME-1, sample `rx_s`.
  - Sample 1: push the byte to the holding stage and go to IDLE. The next start edge is therefore detectable from mid-stop-bit onward.
  - Sample 0: pulse `framing_err`, discard the byte, go to BREAK.
- **BREAK:** wait for `rx_s`==1, then go to IDLE. A held-low line cannot retrigger reception.
- **Holding stage, without FIFO:** a single register plus a valid flag.
  - `valid && ready` clears valid.
  - A push while valid=1 and ready=0: pulse `overrun`, drop the new byte, keep the old byte.
  - A push in the same cycle as `valid && ready`: load the new byte, keep valid=1, no overrun.
- **`data_out` stability:** `data_out` is stable while `data_out_valid`=1 and not accepted.

## Timing
- **Reset values:** `data_out`=0, `data_out_valid`=0, `framing_err`=0, `overrun`=0. FSM=IDLE, `cnt`=0, shift register=0, FIFO empty.
- **Reset mid-frame:** the partial byte is discarded and no pulses are produced. After reset is released, a low line waits for a start detect; the FSM stays in IDLE until `rx_s`=0.
- **Edge to start detect:** the `serial_in` falling edge reaches IDLE detection 2 cycles later.
- **Stop-bit sample:** taken SAMPLE_TIME + 9·SYMBOL_TIME cycles after the start detect, i.e. 475 cycles at the defaults.
- **`data_out_valid` rise:** the clock edge immediately after the stop-bit sample cycle. `framing_err` pulses on that same edge.
- **Throughput:** one byte per 10·SYMBOL_TIME cycles, continuous.
- **Baud tolerance:** a mid-bit sample tolerates ±4% baud mismatch over a frame.
- **Simultaneity:** the pop is evaluated before the push. Full+pop+push never overruns.

## Configuration
- Macro: `UART_RX_FIFO_EN`.
- **Defined:** the holding stage is a 4-entry FIFO (2-bit pointers plus a wrap bit).
  - `data_out` = head entry; `data_out_valid` = not empty.
  - A push while full without a simultaneous pop pulses `overrun` and drops the byte; FIFO contents are unchanged.
  - A push to an empty FIFO makes valid rise on the edge after the stop sample, same as without the FIFO.
  - Pointer wrap-around is correct over more than 4 entries.
- **Undefined:** single-register holding stage as described in Operation.

## Test plan
- **Single byte:** send 0x61 at 1 Mbaud with ready=1 → `data_out`=0x61, valid high exactly 1 cycle, rising 478 cycles after the `serial_in` falling edge. No error pulses.
- **Glitch:** drive `serial_in` low for 10 cycles, then high → no valid, no `framing_err`, FSM back in IDLE.
- **Framing error:** send 0x62 with stop bit 0, then hold the line low for 200 cycles and release → one `framing_err` pulse, no valid. Then send 0x63 → 0x63 received correctly.
- **Back-to-back with ready=0:** send 0x61..0x66 back-to-back, then raise ready.
  - Without FIFO: `overrun` pulses 5 times, only 0x61 is delivered.
  - With FIFO: 0x61..0x64 are delivered in order, `overrun` pulses twice.
- **Simultaneous accept:** complete a byte in the same cycle as `valid && ready` → no overrun, new byte presented on the next cycle.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 → all outputs return to 0, no valid. The next full frame (0x6A) is received correctly.
